// File: rtl/kyber_zeta_streamer.sv
// Twiddle-factor source for the Kyber NTT/INTT: bit-reversed zeta ROM streamed
// in forward or inverse order over valid/ready, with optional negation and scale beat.
module kyber_zeta_streamer #(
    parameter int    DATA_W     = 12,
    parameter int    ADDR_W     = 7,
    parameter int    Q          = 3329,
    parameter int    F_INV      = 1441,
    parameter bit    INV_NEGATE = 1'b1,
    parameter bit    ADD_SCALE  = 1'b1,
    parameter string INIT_FILE  = "zetas.mem"
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              zeta_valid,
    input  logic              zeta_ready,
    output logic [DATA_W-1:0] zeta_data,
    output logic [2:0]        zeta_layer,
    output logic              zeta_last
);

    localparam int                DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] K_MAX       = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] K_ONE       = ADDR_W'(1);
    localparam logic [2:0]        LAYER_TOP   = 3'(ADDR_W - 1);
    localparam logic [2:0]        LAYER_SCALE = 3'(ADDR_W);

    typedef enum logic [1:0] {IDLE, RUN, SCALE, FINISH} state_t;

    // 17^brv(idx) mod Q, evaluated at elaboration to fill the ROM.
    function automatic logic [DATA_W-1:0] zeta_calc(input int idx);
        int e;
        int r;
        int b;
        e = 0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (((idx >> i) & 1) != 0) e = e | (1 << (ADDR_W - 1 - i));
        end
        r = 1;
        b = 17 % Q;
        for (int i = 0; i < ADDR_W; i++) begin
            if (((e >> i) & 1) != 0) r = (r * b) % Q;
            b = (b * b) % Q;
        end
        return DATA_W'(r);
    endfunction

    function automatic logic [2:0] msb_pos(input logic [ADDR_W-1:0] v);
        logic [2:0] p;
        p = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (v[i]) p = 3'(i);
        end
        return p;
    endfunction

    // ---------------------------------------------------------------- ROM
    logic [DATA_W-1:0] rom_table [DEPTH];
    logic [DATA_W-1:0] rom_q_reg;

    // An empty INIT_FILE name means an unprogrammed (all-zero) table.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            if (INIT_FILE == "") begin : g_blank
                assign rom_table[gi] = '0;
            end else begin : g_zeta
                localparam logic [DATA_W-1:0] ZETA = zeta_calc(gi);
                assign rom_table[gi] = ZETA;
            end
        end
    endgenerate

    // ---------------------------------------------------------------- state
    state_t            state_reg;
    state_t            state_next;
    logic              mode_reg;
    logic [ADDR_W-1:0] k_reg;
    logic              issue_done_reg;

    // Stage 1 travels alongside the registered ROM read.
    logic              s1_valid_reg;
    logic [2:0]        s1_layer_reg;
    logic              s1_last_reg;
    logic              s1_scale_reg;

    logic              abort_hit;
    logic              start_hit;
    logic              out_adv;
    logic              s1_adv;
    logic              issue;
    logic              issue_scale;
    logic              issue_last;
    logic [2:0]        issue_layer;
    logic              k_final;
    logic              wants_scale;
    logic              last_hs;
    logic [DATA_W-1:0] s1_word;

    assign busy        = (state_reg == RUN) || (state_reg == SCALE);
    assign done        = (state_reg == FINISH);

    assign abort_hit   = abort && (state_reg != IDLE);
    assign start_hit   = start && !abort && (state_reg == IDLE);
    assign out_adv     = !zeta_valid || zeta_ready;
    assign s1_adv      = !s1_valid_reg || out_adv;
    assign issue       = busy && !issue_done_reg && s1_adv && !abort_hit;
    assign issue_scale = (state_reg == SCALE);
    assign k_final     = mode_reg ? (k_reg == K_ONE) : (k_reg == K_MAX);
    assign wants_scale = mode_reg && ADD_SCALE;
    assign issue_last  = issue_scale || (k_final && !wants_scale);
    assign last_hs     = zeta_valid && zeta_ready && zeta_last;

    always_comb begin
        issue_layer = msb_pos(k_reg);
        if (issue_scale) begin
            issue_layer = LAYER_SCALE;
        end else if (mode_reg) begin
            issue_layer = LAYER_TOP - msb_pos(k_reg);
        end
    end

    // Negation uses one extra bit so Q - zeta never wraps before truncation.
    always_comb begin
        s1_word = rom_q_reg;
        if (s1_scale_reg) begin
            s1_word = DATA_W'(F_INV);
        end else if (mode_reg && INV_NEGATE && (rom_q_reg != '0)) begin
            s1_word = DATA_W'((DATA_W + 1)'(Q) - {1'b0, rom_q_reg});
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_hit) state_next = RUN;
            end
            RUN: begin
                if (issue && k_final && wants_scale) state_next = SCALE;
            end
            SCALE: begin
                state_next = SCALE;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (last_hs && busy) state_next = FINISH;
        if (abort_hit) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------- address counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_reg       <= 1'b0;
            k_reg          <= '0;
            issue_done_reg <= 1'b0;
        end else if (start_hit) begin
            mode_reg       <= mode;
            k_reg          <= mode ? K_MAX : K_ONE;
            issue_done_reg <= 1'b0;
        end else if (issue) begin
            if (issue_last) issue_done_reg <= 1'b1;
            if (!issue_scale) k_reg <= mode_reg ? (k_reg - K_ONE) : (k_reg + K_ONE);
        end
    end

    // ROM enable follows issue, so a stalled stage 1 keeps its read word.
    always_ff @(posedge clk) begin
        if (issue) rom_q_reg <= rom_table[k_reg];
    end

    // ---------------------------------------------------------------- pipeline
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_reg <= 1'b0;
            s1_layer_reg <= '0;
            s1_last_reg  <= 1'b0;
            s1_scale_reg <= 1'b0;
        end else if (abort_hit) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= issue;
            if (issue) begin
                s1_layer_reg <= issue_layer;
                s1_last_reg  <= issue_last;
                s1_scale_reg <= issue_scale;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            zeta_valid <= 1'b0;
            zeta_data  <= '0;
            zeta_layer <= '0;
            zeta_last  <= 1'b0;
        end else if (abort_hit) begin
            zeta_valid <= 1'b0;
        end else if (out_adv) begin
            zeta_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                zeta_data  <= s1_word;
                zeta_layer <= s1_layer_reg;
                zeta_last  <= s1_last_reg;
            end
        end
    end

endmodule

// File: tb/tb_kyber_zeta_streamer.sv
// Randomised-backpressure bench for kyber_zeta_streamer: a queue model built from
// the 17^brv7(k) rule is checked on every accepted beat and every stalled cycle.
module tb_kyber_zeta_streamer;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 7;
    localparam int Q      = 3329;
    localparam int F_INV  = 1441;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic              mode;
    logic              abort;
    logic              zeta_ready;
    logic              busy;
    logic              done;
    logic              zeta_valid;
    logic [DATA_W-1:0] zeta_data;
    logic [2:0]        zeta_layer;
    logic              zeta_last;

    kyber_zeta_streamer dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .mode       (mode),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .zeta_valid (zeta_valid),
        .zeta_ready (zeta_ready),
        .zeta_data  (zeta_data),
        .zeta_layer (zeta_layer),
        .zeta_last  (zeta_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [2:0]        l;
        logic              last;
    } beat_t;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc_cnt  = 0;
    int    hs_edge  = -1;
    int    exp_len  = 0;
    int    ready_pct = 100;
    bit    allow_drop = 1'b0;
    bit    stall_prev = 1'b0;
    beat_t prev_beat;
    beat_t cur_beat;
    beat_t exp_beat;
    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t fwd_ref[$];
    beat_t inv_ref[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // ---------------------------------------------------------------- model
    function automatic int brv(input int k);
        int r = 0;
        for (int i = 0; i < ADDR_W; i++)
            if ((k & (1 << i)) != 0) r |= 1 << (ADDR_W - 1 - i);
        return r;
    endfunction

    function automatic int zeta_ref(input int k);
        int r = 1;
        int e = brv(k);
        for (int i = 0; i < e; i++) r = (r * 17) % Q;
        return r;
    endfunction

    function automatic int flog2(input int k);
        int l = 0;
        while ((k >> (l + 1)) != 0) l++;
        return l;
    endfunction

    function automatic beat_t mk(input int d, input int l, input bit last);
        beat_t b;
        b.d    = DATA_W'(d);
        b.l    = 3'(l);
        b.last = last;
        return b;
    endfunction

    task automatic build_expected(input logic m);
        exp_q.delete();
        if (!m) begin
            for (int k = 1; k < DEPTH; k++)
                exp_q.push_back(mk(zeta_ref(k), flog2(k), k == DEPTH - 1));
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                int z = zeta_ref(k);
                exp_q.push_back(mk((z == 0) ? 0 : Q - z, ADDR_W - 1 - flog2(k), 1'b0));
            end
            exp_q.push_back(mk(F_INV, ADDR_W, 1'b1));
        end
        exp_len = exp_q.size();
    endtask

    // ---------------------------------------------------------------- compare process
    always @(negedge clk) begin
        cur_beat = {zeta_data, zeta_layer, zeta_last};
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && !allow_drop) check("valid_held", int'(zeta_valid), 1);
            if (stall_prev && zeta_valid) begin
                n_checks++;
                if (cur_beat == prev_beat) n_pass++;
                else $display("FAIL hold: got %h, expected %h while stalled", cur_beat, prev_beat);
            end
            if (zeta_valid && zeta_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat_extra: got data=%0d layer=%0d last=%0d, expected no beat",
                             zeta_data, zeta_layer, zeta_last);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (cur_beat == exp_beat) n_pass++;
                    else $display("FAIL beat[%0d]: got data=%0d layer=%0d last=%0d, expected data=%0d layer=%0d last=%0d",
                                  got_q.size(), zeta_data, zeta_layer, zeta_last,
                                  exp_beat.d, exp_beat.l, exp_beat.last);
                end
                got_q.push_back(cur_beat);
                if (zeta_last) hs_edge = cyc_cnt + 1;
            end
            stall_prev = zeta_valid && !zeta_ready;
            prev_beat  = cur_beat;
        end
    end

    initial begin
        zeta_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            zeta_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ---------------------------------------------------------------- sequences
    // Called #1 after a posedge; start is sampled at the next edge.
    task automatic start_seq(input logic m, input int pct);
        build_expected(m);
        got_q.delete();
        hs_edge    = -1;
        allow_drop = 1'b0;
        ready_pct  = pct;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'($urandom);
        check("busy_after_start", int'(busy), 1);
        check("valid_at_t0", int'(zeta_valid), 0);
        @(posedge clk); #1;
        check("valid_at_t1", int'(zeta_valid), 0);
        @(posedge clk); #1;
        check("valid_at_t2", int'(zeta_valid), 1);
    endtask

    task automatic finish_seq(input bit poke);
        bit got_done = 1'b0;
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) got_done = 1'b1;
            else if (poke && busy && ($urandom_range(0, 3) == 0)) begin
                start = 1'b1;
                mode  = 1'($urandom);
            end
        end
        start = 1'b0;
        check("done_seen", int'(got_done), 1);
        check("done_after_last_hs", cyc_cnt, hs_edge);
        check("busy_low_at_done", int'(busy), 0);
        check("beat_count", got_q.size(), exp_len);
        check("model_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
    endtask

    task automatic compare_runs(input string name, input beat_t ref_q[$]);
        int diffs = 0;
        check({name, "_len"}, got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] != ref_q[i]) diffs++;
        check({name, "_diffs"}, diffs, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_valid"}, int'(zeta_valid), 0);
        check({tag, "_data"}, int'(zeta_data), 0);
        check({tag, "_layer"}, int'(zeta_layer), 0);
        check({tag, "_last"}, int'(zeta_last), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        resetn = 1'b0;
        start  = 1'b0;
        mode   = 1'b0;
        abort  = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Forward, ready held high, with literal pins on the model.
        start_seq(1'b0, 100);
        finish_seq(1'b0);
        check("fwd_b0", int'(got_q[0].d), 1729);
        check("fwd_b1", int'(got_q[1].d), 2580);
        check("fwd_b2", int'(got_q[2].d), 3289);
        check("fwd_l0", int'(got_q[0].l), 0);
        check("fwd_l1", int'(got_q[1].l), 1);
        check("fwd_l2", int'(got_q[2].l), 1);
        check("fwd_len", got_q.size(), 127);
        check("fwd_lastdata", int'(got_q[126].d), 2154);
        check("fwd_lastlayer", int'(got_q[126].l), 6);
        check("fwd_lastflag", int'(got_q[126].last), 1);
        fwd_ref = got_q;

        // Inverse, ready held high.
        start_seq(1'b1, 100);
        finish_seq(1'b0);
        check("inv_b0", int'(got_q[0].d), 1175);
        check("inv_b1", int'(got_q[1].d), 2444);
        check("inv_l0", int'(got_q[0].l), 0);
        check("inv_len", got_q.size(), 128);
        check("inv_rom_last_flag", int'(got_q[126].last), 0);
        check("inv_scale_data", int'(got_q[127].d), 1441);
        check("inv_scale_layer", int'(got_q[127].l), 7);
        check("inv_scale_last", int'(got_q[127].last), 1);
        inv_ref = got_q;

        // Random backpressure, with start pulses while busy.
        start_seq(1'b0, 50);
        finish_seq(1'b1);
        compare_runs("fwd_bp", fwd_ref);
        start_seq(1'b1, 50);
        finish_seq(1'b1);
        compare_runs("inv_bp", inv_ref);

        // Abort at beat 40, then immediate restart.
        start_seq(1'b0, 100);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk); #1;
            if (got_q.size() >= 40) reached = 1'b1;
        end
        check("abort_reach_40", int'(reached), 1);
        abort = 1'b1;
        allow_drop = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", int'(zeta_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        exp_q.delete();
        start_seq(1'b0, 100);
        finish_seq(1'b0);
        check("restart_b0", int'(got_q[0].d), 1729);

        // abort and start in the same IDLE cycle: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start_busy", int'(busy), 0);
        @(posedge clk); #1;
        check("abort_beats_start_valid", int'(zeta_valid), 0);

        // Reset mid-inverse, then a full forward run straight after release.
        start_seq(1'b1, 50);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk); #1;
            if (got_q.size() >= 30) reached = 1'b1;
        end
        check("reset_reach_30", int'(reached), 1);
        #3;
        allow_drop = 1'b1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        start_seq(1'b0, 100);
        finish_seq(1'b0);
        compare_runs("after_reset", fwd_ref);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
